filter_buf_responder: RTL and testbench

//  Filter-side responder for pe_engine's weight fetch interface (fb_req/fb_addr -> fb_data0..3).

---
 rtl/filter_buf_responder.sv | 127 ++++++++++++
 tb/tb_filter_buf_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_buf_responder.sv
// Filter buffer for pe_engine: loads TOUT banks of filter taps from a serial write stream and
// answers weight reads with a fixed one-cycle latency.
module filter_buf_responder #(
  parameter int FILTER_DW = 72,
  parameter int TOUT      = 4,
  parameter int DEPTH     = 16,
  parameter int AW        = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_load_start,
  input  logic [AW:0]          i_num_entries,
  input  logic                 i_wr_valid,
  input  logic [FILTER_DW-1:0] i_wr_data,
  output logic                 o_wr_ready,
  output logic                 o_filter_buf_done,
  output logic                 o_loaded,
  input  logic                 i_fb_req,
  input  logic [AW-1:0]        i_fb_addr,
  output logic [FILTER_DW-1:0] o_fb_data0,
  output logic [FILTER_DW-1:0] o_fb_data1,
  output logic [FILTER_DW-1:0] o_fb_data2,
  output logic [FILTER_DW-1:0] o_fb_data3,
  output logic                 o_fb_valid,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  localparam int              BW        = (TOUT > 1) ? $clog2(TOUT) : 1;
  localparam logic [AW:0]     DEPTH_L   = (AW+1)'(DEPTH);
  localparam logic [BW-1:0]   LAST_BANK = BW'(TOUT-1);

  state_t               state_q, state_d;
  logic [AW:0]          num_q, num_d;
  logic [BW-1:0]        bank_q, bank_d;
  logic [AW-1:0]        entry_q, entry_d;
  logic                 done_q, done_d;
  logic                 fb_valid_q;
  logic [FILTER_DW-1:0] rd_q [TOUT];
  logic [FILTER_DW-1:0] mem_q [TOUT][DEPTH];

  logic        wr_acc, last_word, rd_acc, addr_oob;
  logic [AW:0] num_eff;

  // Write stream handshake: a word transfers in any cycle where i_wr_valid && o_wr_ready;
  // the producer holds i_wr_data while valid is high and ready is low. A start pulse in the
  // same cycle takes priority and the word is not taken.
  assign num_eff   = (i_num_entries == '0 || i_num_entries > DEPTH_L) ? DEPTH_L : i_num_entries;
  assign wr_acc    = i_wr_valid && (state_q == ST_LOAD) && !i_load_start;
  assign last_word = (bank_q == LAST_BANK) && ({1'b0, entry_q} == num_q - (AW+1)'(1));
  assign rd_acc    = i_fb_req && (state_q == ST_READY) && !i_load_start;
  assign addr_oob  = {1'b0, i_fb_addr} >= num_q;

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    bank_d  = bank_q;
    entry_d = entry_q;
    done_d  = 1'b0;
    if (i_load_start) begin
      state_d = ST_LOAD;
      num_d   = num_eff;
      bank_d  = '0;
      entry_d = '0;
    end else if (wr_acc) begin
      // Entry-major order: all banks of one entry before moving to the next entry.
      if (last_word) begin
        state_d = ST_READY;
        done_d  = 1'b1;
        bank_d  = '0;
        entry_d = '0;
      end else if (bank_q == LAST_BANK) begin
        bank_d  = '0;
        entry_d = entry_q + AW'(1);
      end else begin
        bank_d  = bank_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      num_q      <= '0;
      bank_q     <= '0;
      entry_q    <= '0;
      done_q     <= 1'b0;
      fb_valid_q <= 1'b0;
      for (int b = 0; b < TOUT; b++) rd_q[b] <= '0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      bank_q     <= bank_d;
      entry_q    <= entry_d;
      done_q     <= done_d;
      fb_valid_q <= rd_acc;
      if (rd_acc) begin
        for (int b = 0; b < TOUT; b++) rd_q[b] <= addr_oob ? '0 : mem_q[b][i_fb_addr];
      end
    end
  end

  // Tap storage is left unreset; only completed sets are ever read back.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int b = 0; b < TOUT; b++) begin
        if (bank_q == BW'(b)) mem_q[b][entry_q] <= i_wr_data;
      end
    end
  end

  assign o_wr_ready        = (state_q == ST_LOAD);
  assign o_loaded          = (state_q == ST_READY);
  assign o_filter_buf_done = done_q;
  assign o_fb_valid        = fb_valid_q;
  assign o_fb_data0        = rd_q[0];
  assign o_fb_data1        = rd_q[1];
  assign o_fb_data2        = rd_q[2];
  assign o_fb_data3        = rd_q[3];
  assign o_dbg_state       = state_q;

endmodule

// File: tb/tb_filter_buf_responder.sv
// Bench for filter_buf_responder: loads filter sets against a bank model and checks every
// read response through an expected-value queue.
module tb_filter_buf_responder;

  localparam int DW = 72;
  localparam int W  = 4 * DW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          i_load_start = 1'b0;
  logic [4:0]    i_num_entries = '0;
  logic          i_wr_valid = 1'b0;
  logic [DW-1:0] i_wr_data = '0;
  logic          o_wr_ready, o_filter_buf_done, o_loaded, o_fb_valid;
  logic          i_fb_req = 1'b0;
  logic [3:0]    i_fb_addr = '0;
  logic [DW-1:0] o_fb_data0, o_fb_data1, o_fb_data2, o_fb_data3;
  logic [1:0]    o_dbg_state;

  always #5 clk = ~clk;

  filter_buf_responder dut (
    .clk               (clk),
    .rstn              (rstn),
    .i_load_start      (i_load_start),
    .i_num_entries     (i_num_entries),
    .i_wr_valid        (i_wr_valid),
    .i_wr_data         (i_wr_data),
    .o_wr_ready        (o_wr_ready),
    .o_filter_buf_done (o_filter_buf_done),
    .o_loaded          (o_loaded),
    .i_fb_req          (i_fb_req),
    .i_fb_addr         (i_fb_addr),
    .o_fb_data0        (o_fb_data0),
    .o_fb_data1        (o_fb_data1),
    .o_fb_data2        (o_fb_data2),
    .o_fb_data3        (o_fb_data3),
    .o_fb_valid        (o_fb_valid),
    .o_dbg_state       (o_dbg_state)
  );

  logic [W-1:0]  exp_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            done_cnt = 0;
  logic [DW-1:0] model [4][16];
  int            num_model = 16;
  bit            model_ready = 1'b0;

  typedef struct {
    logic [4:0] num;
    int         words;
  } load_vec_t;

  load_vec_t vecs [6];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] exp_word(input int addr);
    if (addr >= num_model) return '0;
    return {model[3][addr], model[2][addr], model[1][addr], model[0][addr]};
  endfunction

  // Response monitor: every valid beat must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (o_filter_buf_done === 1'b1) done_cnt++;
    if (o_fb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: got valid=1 want no response");
      end else begin
        chkw("fb_read", {o_fb_data3, o_fb_data2, o_fb_data1, o_fb_data0}, exp_q.pop_front());
      end
    end
  end

  task automatic rd_seq(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      i_fb_req  = 1'b1;
      i_fb_addr = 4'(start + i);
      if (model_ready) exp_q.push_back(exp_word(start + i));
      tick();
    end
    i_fb_req = 1'b0;
  endtask

  task automatic load_set(input logic [4:0] num, input int n_send, input bit gaps,
                          input bit expect_done, input bit special);
    logic [DW-1:0] wbuf [64];
    logic [95:0]   r;
    int            acc, cyc, dc0;
    bit            took;
    for (int k = 0; k < 64; k++) begin
      r = {$urandom(), $urandom(), $urandom()};
      wbuf[k] = r[DW-1:0];
    end
    if (special) begin
      wbuf[8]  = 72'h10f00031efe106fffb;
      wbuf[15] = 72'h19f616f9e009faebf8;
    end
    dc0 = done_cnt;
    i_load_start  = 1'b1;
    i_num_entries = num;
    tick();
    i_load_start = 1'b0;
    num_model    = (num == 0 || num > 16) ? 16 : int'(num);
    model_ready  = 1'b0;
    acc = 0;
    cyc = 0;
    while (acc < n_send && cyc < 400) begin
      i_wr_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      i_wr_data  = wbuf[acc];
      took = i_wr_valid && o_wr_ready;
      tick();
      cyc++;
      if (took) begin
        model[acc % 4][acc / 4] = wbuf[acc];
        acc++;
      end
    end
    i_wr_valid = 1'b0;
    chk1("load_accept_count", acc == n_send, 1'b1);
    if (expect_done) begin
      chk1("done_after_last", o_filter_buf_done, 1'b1);
      chk1("loaded_after_last", o_loaded, 1'b1);
      tick();
      chk1("done_one_cycle", o_filter_buf_done, 1'b0);
      chk1("done_pulse_count", (done_cnt - dc0) == 1, 1'b1);
      model_ready = 1'b1;
    end else begin
      chk1("no_done_partial", o_filter_buf_done, 1'b0);
      chk1("no_done_count", done_cnt == dc0, 1'b1);
      chk1("not_loaded_partial", o_loaded, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want test completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{num: 5'd4,  words: 16};
    vecs[1] = '{num: 5'd0,  words: 64};
    vecs[2] = '{num: 5'd20, words: 64};
    vecs[3] = '{num: 5'd16, words: 64};
    vecs[4] = '{num: 5'd1,  words: 4};
    vecs[5] = '{num: 5'd15, words: 60};

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    chk1("rst_wr_ready", o_wr_ready, 1'b0);
    chk1("rst_done", o_filter_buf_done, 1'b0);
    chk1("rst_loaded", o_loaded, 1'b0);
    chk1("rst_valid", o_fb_valid, 1'b0);
    chk1("rst_state_idle", o_dbg_state == 2'd0, 1'b1);
    chkw("rst_data", {o_fb_data3, o_fb_data2, o_fb_data1, o_fb_data0}, '0);
    rstn = 1'b1;
    tick();

    // Basic load and reads
    load_set(5'd4, 16, 1'b0, 1'b1, 1'b1);
    rd_seq(2, 1);
    chk1("read_valid", o_fb_valid, 1'b1);
    chkw("bank0_entry2", W'(o_fb_data0), W'(72'h10f00031efe106fffb));
    rd_seq(3, 1);
    chkw("bank3_entry3", W'(o_fb_data3), W'(72'h19f616f9e009faebf8));
    rd_seq(0, 4);
    tick();
    chk1("valid_drops_idle", o_fb_valid, 1'b0);
    chkw("data_holds", {o_fb_data3, o_fb_data2, o_fb_data1, o_fb_data0}, exp_word(3));

    // Gapped write stream, out-of-range read
    load_set(5'd4, 16, 1'b1, 1'b1, 1'b1);
    rd_seq(0, 16);
    rd_seq(5, 1);
    chk1("oob_valid", o_fb_valid, 1'b1);
    chkw("oob_zero", {o_fb_data3, o_fb_data2, o_fb_data1, o_fb_data0}, '0);

    // Aborted load, read during LOAD, restart
    load_set(5'd4, 7, 1'b0, 1'b0, 1'b0);
    i_fb_req  = 1'b1;
    i_fb_addr = 4'd0;
    tick();
    i_fb_req = 1'b0;
    chk1("req_in_load_ignored", o_fb_valid, 1'b0);
    load_set(5'd4, 16, 1'b0, 1'b1, 1'b0);
    rd_seq(0, 4);

    // Start and request in the same cycle: start wins
    i_load_start  = 1'b1;
    i_num_entries = 5'd4;
    i_fb_req      = 1'b1;
    i_fb_addr     = 4'd1;
    tick();
    i_load_start = 1'b0;
    i_fb_req     = 1'b0;
    model_ready  = 1'b0;
    chk1("start_req_no_valid", o_fb_valid, 1'b0);
    chk1("start_clears_loaded", o_loaded, 1'b0);
    load_set(5'd4, 16, 1'b1, 1'b1, 1'b0);
    rd_seq(0, 4);

    // Entry-count table: zero and oversized counts mean a full DEPTH set
    for (int i = 0; i < 6; i++) begin
      load_set(vecs[i].num, vecs[i].words, 1'(i % 2), 1'b1, 1'b0);
      rd_seq(0, 16);
    end

    // Asynchronous reset in the middle of a load
    load_set(5'd0, 5, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk1("midrst_wr_ready", o_wr_ready, 1'b0);
    chk1("midrst_loaded", o_loaded, 1'b0);
    chk1("midrst_state_idle", o_dbg_state == 2'd0, 1'b1);
    @(posedge clk);
    #1;
    rstn        = 1'b1;
    model_ready = 1'b0;
    i_fb_req    = 1'b1;
    i_fb_addr   = 4'd0;
    tick();
    i_fb_req = 1'b0;
    chk1("read_after_reset_ignored", o_fb_valid, 1'b0);
    chk1("idle_after_reset", o_dbg_state == 2'd0, 1'b1);

    repeat (3) tick();
    chk1("queue_drained", exp_q.size() == 0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
